// File: rtl/sblk_pkg.sv
// Shared superblock package: conv configuration widths, drain FSM states and the
// psum requantise helper. Define SBLK_DRAIN_RELU_EN to clamp negative results to zero.
package sblk_pkg;

    // Shared conv configuration.
    localparam int PBUF_ADDR_LEN = 8;
    localparam int PSUM_DATA_LEN = 32;

    // Requantiser datapath width; partial sums up to this width are supported.
    localparam int REQ_W = 64;
    localparam logic signed [REQ_W:0] Q_MAX = 65'sd127;
    localparam logic signed [REQ_W:0] Q_MIN = -65'sd128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

    // Round-half-up arithmetic right shift followed by int8 saturation.
    function automatic logic [7:0] requant(input logic signed [REQ_W-1:0] p,
                                           input logic [4:0]              s);
        logic signed [REQ_W:0] rnd;
        logic signed [REQ_W:0] sum;
        logic signed [REQ_W:0] r;
        logic [7:0]            q;
        rnd = '0;
        if (s != 5'd0) begin
            rnd = {{REQ_W{1'b0}}, 1'b1} << (s - 5'd1);
        end else begin
            rnd = '0;
        end
        sum = {p[REQ_W-1], p} + rnd;
        r   = sum >>> s;
`ifdef SBLK_DRAIN_RELU_EN
        if (r[REQ_W]) begin
            r = '0;
        end else begin
            r = r;
        end
`endif
        if (r > Q_MAX) begin
            q = 8'h7F;
        end else if (r < Q_MIN) begin
            q = 8'h80;
        end else begin
            q = r[7:0];
        end
        return q;
    endfunction

endpackage

// File: rtl/sblk_drain_fifo.sv
// Output skid FIFO for the psum drain: first-word-fall-through, DEPTH a power of 2.
module sblk_drain_fifo
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk_l,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against full/empty.
    always_comb begin
        do_push_s = push && (count_r != FULL_CNT);
        do_pop_s  = pop && (count_r != '0);
    end

    // Storage array; cleared on reset so the head reads zero.
    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; simultaneous push and pop keeps the count.
    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

endmodule

// File: rtl/sblk_psum_drain.sv
// Drains a block of psum-buffer words, requantises each psum pair to int8 and streams
// them out through a skid FIFO. Define SBLK_DRAIN_RELU_EN for ReLU before saturation.
module sblk_psum_drain
    import sblk_pkg::*;
#(
    parameter int PSUM_W     = PSUM_DATA_LEN,
    parameter int RD_LAT     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk_l,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PBUF_ADDR_LEN-1:0] cfg_base_addr,
    input  logic [PBUF_ADDR_LEN:0]   cfg_len,
    input  logic [4:0]               cfg_shift,
    output logic                     busy,
    output logic                     done,
    output logic [PBUF_ADDR_LEN-1:0] pbuf_rd_addr,
    input  logic [2*PSUM_W-1:0]      pbuf_rd_data,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PBUF_ADDR_LEN:0] LEN_ONE = {{PBUF_ADDR_LEN{1'b0}}, 1'b1};
    localparam logic [FC_W-1:0]        FC_ONE  = {{(FC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]       CREDITS = FIFO_DEPTH[CNT_W-1:0];

    drain_state_e               state_r;
    drain_state_e               state_nxt_s;
    logic [PBUF_ADDR_LEN-1:0]   next_addr_r;
    logic [PBUF_ADDR_LEN-1:0]   rd_addr_r;
    logic [PBUF_ADDR_LEN:0]     rem_r;
    logic [4:0]                 shift_r;
    logic                       addr_vld_r;
    logic [RD_LAT-1:0]          rd_vld_r;
    logic                       rq_vld_r;
    logic [15:0]                rq_data_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       issue_s;
    logic                       load_s;
    logic                       drained_s;
    logic                       fifo_pop_s;
    logic [CNT_W-1:0]           credit_s;
    logic [FC_W-1:0]            fifo_count_s;
    logic signed [PSUM_W-1:0]   psum_lo_s;
    logic signed [PSUM_W-1:0]   psum_hi_s;

    assign psum_lo_s = pbuf_rd_data[PSUM_W-1:0];
    assign psum_hi_s = pbuf_rd_data[2*PSUM_W-1:PSUM_W];

    // Credits: everything issued but not yet popped, including the bus and requant stages.
    always_comb begin
        credit_s = CNT_W'(addr_vld_r) + CNT_W'(rq_vld_r) + CNT_W'(fifo_count_s);
        for (int i = 0; i < RD_LAT; i++) begin
            credit_s = credit_s + CNT_W'(rd_vld_r[i]);
        end
        drained_s = !addr_vld_r && (rd_vld_r == '0) && !rq_vld_r &&
                    ((fifo_count_s == '0) || ((fifo_count_s == FC_ONE) && out_ready));
    end

    // Next-state and issue decode.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = (cfg_len != '0) ? RUN : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (credit_s < CREDITS) begin
                    issue_s     = 1'b1;
                    state_nxt_s = (rem_r == LEN_ONE) ? FLUSH : RUN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSH: begin
                if (drained_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with registered status outputs.
    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Config capture and read-address generation; the address holds between issues.
    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            next_addr_r <= '0;
            rd_addr_r   <= '0;
            rem_r       <= '0;
            shift_r     <= 5'd0;
            addr_vld_r  <= 1'b0;
        end else begin
            addr_vld_r <= issue_s;
            if (load_s) begin
                next_addr_r <= cfg_base_addr;
                rem_r       <= cfg_len;
                shift_r     <= cfg_shift;
            end else if (issue_s) begin
                rd_addr_r   <= next_addr_r;
                next_addr_r <= next_addr_r + 1'b1;
                rem_r       <= rem_r - 1'b1;
            end else begin
                rd_addr_r   <= rd_addr_r;
            end
        end
    end

    // Read-latency tracker and requantisation stage feeding the FIFO.
    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            rd_vld_r  <= '0;
            rq_vld_r  <= 1'b0;
            rq_data_r <= 16'h0000;
        end else begin
            rd_vld_r[0] <= addr_vld_r;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_r[i] <= rd_vld_r[i-1];
            end
            rq_vld_r <= rd_vld_r[RD_LAT-1];
            if (rd_vld_r[RD_LAT-1]) begin
                rq_data_r <= {requant(REQ_W'(psum_hi_s), shift_r),
                              requant(REQ_W'(psum_lo_s), shift_r)};
            end else begin
                rq_data_r <= rq_data_r;
            end
        end
    end

    assign fifo_pop_s = out_valid && out_ready;

    sblk_drain_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_l     (clk_l),
        .rst_n     (rst_n),
        .push      (rq_vld_r),
        .push_data (rq_data_r),
        .pop       (fifo_pop_s),
        .rd_data   (out_data),
        .count     (fifo_count_s)
    );

    assign out_valid    = (fifo_count_s != '0);
    assign busy         = busy_r;
    assign done         = done_r;
    assign pbuf_rd_addr = rd_addr_r;

endmodule

// File: tb/tb_sblk_psum_drain.sv
// Randomised bench for sblk_psum_drain with a queue-based reference model and psum memory.
module tb_sblk_psum_drain;

    localparam int TB_RD_LAT = 3;
    localparam int AL        = sblk_pkg::PBUF_ADDR_LEN;

    logic            clk_l = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AL-1:0]   cfg_base_addr = '0;
    logic [AL:0]     cfg_len = '0;
    logic [4:0]      cfg_shift = 5'd0;
    logic            busy;
    logic            done;
    logic [AL-1:0]   pbuf_rd_addr;
    logic [63:0]     pbuf_rd_data;
    logic [15:0]     out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;

    logic [63:0]     mem [256];
    logic [AL-1:0]   ah [TB_RD_LAT];
    logic [AL-1:0]   expaddr [$];
    logic [15:0]     expq [$];
    logic [15:0]     given_q [$];
    int              vec_cnt = 0;
    int              err_cnt = 0;
    int              cyc_cnt = 0;
    int              last_hs = 0;
    int              issued = 0;
    int              popped = 0;
    bit              rst_seen = 1'b1;
    bit              prev_stall = 1'b0;
    logic [AL-1:0]   prev_addr = '0;
    logic [15:0]     held = 16'h0000;

    sblk_psum_drain #(.PSUM_W(32), .RD_LAT(TB_RD_LAT), .FIFO_DEPTH(4)) dut (
        .clk_l(clk_l), .rst_n(rst_n), .start(start), .cfg_base_addr(cfg_base_addr),
        .cfg_len(cfg_len), .cfg_shift(cfg_shift), .busy(busy), .done(done),
        .pbuf_rd_addr(pbuf_rd_addr), .pbuf_rd_data(pbuf_rd_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk_l = ~clk_l;

    // Psum buffer: data for an address appears TB_RD_LAT cycles after it is presented.
    always @(posedge clk_l) begin
        cyc_cnt <= cyc_cnt + 1;
        ah[0]   <= pbuf_rd_addr;
        for (int i = 1; i < TB_RD_LAT; i++) ah[i] <= ah[i-1];
    end
    assign pbuf_rd_data = mem[ah[TB_RD_LAT-1]];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_q(input logic [31:0] pw, input int s);
        longint p, r;
        p = longint'($signed(pw));
        r = p;
        if (s > 0) r = p + (longint'(1) << (s - 1));
        r = r >>> s;
`ifdef SBLK_DRAIN_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
        return r[7:0];
    endfunction

    function automatic logic [15:0] ref_out(input logic [63:0] w, input int s);
        return {ref_q(w[63:32], s), ref_q(w[31:0], s)};
    endfunction

    function automatic logic [31:0] rand_psum();
        case ($urandom_range(2, 0))
            0:       return $urandom;
            1:       return 32'($urandom_range(4000, 0)) - 32'd2000;
            default: return 32'($urandom_range(300, 0)) - 32'd150;
        endcase
    endfunction

    // Output-side monitor: address order, credit bound, output order and hold.
    always @(negedge clk_l) begin
        if (!rst_n) begin
            rst_seen = 1'b1;
        end else if (rst_seen) begin
            rst_seen   = 1'b0;
            prev_addr  = pbuf_rd_addr;
            prev_stall = 1'b0;
            issued     = 0;
            popped     = 0;
        end else begin
            if (pbuf_rd_addr != prev_addr) begin
                issued++;
                if (expaddr.size() != 0) check_val("rd_addr", pbuf_rd_addr, expaddr.pop_front());
                else check_val("extra_read", pbuf_rd_addr, prev_addr);
                check_val("credit", (issued - popped) <= 4, 1);
                prev_addr = pbuf_rd_addr;
            end
            if (prev_stall) check_val("hold", {out_valid, out_data}, {1'b1, held});
            if (out_valid && out_ready) begin
                popped++;
                last_hs = cyc_cnt;
                if (expq.size() != 0) check_val("out_data", out_data, expq.pop_front());
                else check_val("extra_out", out_valid, 0);
            end
            prev_stall = out_valid && !out_ready;
            held       = out_data;
        end
    end

    task automatic fill(input logic [AL-1:0] base, input int len);
        for (int i = 0; i < len; i++) mem[8'(base + 8'(i))] = {rand_psum(), rand_psum()};
    endtask

    task automatic kick(input logic [AL-1:0] base, input logic [AL:0] len, input logic [4:0] sh);
        for (int i = 0; i < int'(len); i++) begin
            logic [AL-1:0] a;
            a = base + 8'(i);
            expaddr.push_back(a);
            if (given_q.size() != 0) expq.push_back(given_q.pop_front());
            else expq.push_back(ref_out(mem[a], int'(sh)));
        end
        @(posedge clk_l); #1;
        start = 1'b1; cfg_base_addr = base; cfg_len = len; cfg_shift = sh;
        @(posedge clk_l); #1;
        start = 1'b0; cfg_base_addr = 8'($urandom); cfg_len = 9'($urandom); cfg_shift = 5'($urandom);
    endtask

    // mode 0: ready high, 1: ready low for `stall` cycles, 2: random ready.
    task automatic wait_done(input int mode, input int stall, input bit inject, input int limit);
        bit got;
        got = 1'b0;
        for (int cyc = 0; cyc < limit; cyc++) begin
            @(negedge clk_l);
            if (done) begin got = 1'b1; break; end
            @(posedge clk_l); #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc + 1 >= stall);
                default: out_ready = ($urandom_range(9, 0) < 7);
            endcase
            start = inject && (cyc == 2);
            if (start) begin
                cfg_base_addr = 8'($urandom); cfg_len = 9'($urandom_range(20, 1)); cfg_shift = 5'($urandom);
            end
        end
        start = 1'b0;
        if (!got) begin
            check_val("done_timeout", done, 1);
        end else begin
            check_val("done_lag", cyc_cnt - last_hs, 1);
            check_val("busy_at_done", busy, 1);
            check_val("all_out", expq.size(), 0);
            check_val("all_rd", expaddr.size(), 0);
        end
        @(posedge clk_l); #1;
        out_ready = 1'b1;
        @(negedge clk_l);
        check_val("idle_after", {busy, done}, 0);
    endtask

    task automatic rand_drain();
        logic [AL-1:0] base;
        int            len;
        logic [4:0]    sh;
        do base = 8'($urandom); while (base == pbuf_rd_addr);
        len = $urandom_range(20, 1);
        sh  = ($urandom_range(1, 0) == 1) ? 5'($urandom_range(8, 0)) : 5'($urandom);
        fill(base, len);
        kick(base, 9'(len), sh);
        wait_done(2, 0, ($urandom_range(1, 0) == 1), 300 + 10 * len);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        repeat (3) @(posedge clk_l);
        #1 rst_n = 1'b1;
        @(negedge clk_l);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_addr", pbuf_rd_addr, 0);
        check_val("rst_data", out_data, 0);

        // Directed four-word drain, shift 0.
        mem[8'h10] = {32'd2, 32'd1};
        mem[8'h11] = {32'd4, -32'sd3};
        mem[8'h12] = {32'd127, 32'd0};
        mem[8'h13] = {32'd5, -32'sd128};
        given_q = '{16'h0201, 16'h04FD, 16'h7F00, 16'h0580};
        kick(8'h10, 9'd4, 5'd0);
        wait_done(0, 0, 1'b0, 100);

        // Rounding with shift 4.
        mem[8'h20] = {32'd24, -32'sd9};
        given_q = '{16'h02FF};
        kick(8'h20, 9'd1, 5'd4);
        wait_done(0, 0, 1'b0, 100);

        // Saturation.
        mem[8'h30] = {32'd1000, -32'sd1000};
`ifdef SBLK_DRAIN_RELU_EN
        given_q = '{16'h7F00};
`else
        given_q = '{16'h7F80};
`endif
        kick(8'h30, 9'd1, 5'd0);
        wait_done(0, 0, 1'b0, 100);

        // Backpressure: 16 words, downstream stalled for 20 cycles.
        fill(8'h40, 16);
        out_ready = 1'b0;
        kick(8'h40, 9'd16, 5'd2);
        wait_done(1, 20, 1'b0, 400);

        // Address wrap.
        fill(8'hFF, 3);
        kick(8'hFF, 9'd3, 5'd1);
        wait_done(2, 0, 1'b0, 200);

        // Zero-length start: done next cycle, address untouched.
        kick(8'h55, 9'd0, 5'd0);
        @(negedge clk_l);
        check_val("len0_done", done, 1);
        check_val("len0_addr", pbuf_rd_addr, 8'h01);
        @(negedge clk_l);
        check_val("len0_idle", {busy, done}, 0);
        check_val("len0_addr2", pbuf_rd_addr, 8'h01);

        // Reset in the middle of a drain.
        fill(8'h80, 16);
        kick(8'h80, 9'd16, 5'd0);
        repeat (5) @(posedge clk_l);
        #1 rst_n = 1'b0;
        expq.delete();
        expaddr.delete();
        @(posedge clk_l); #1 rst_n = 1'b1;
        @(negedge clk_l);
        check_val("mrst_busy", busy, 0);
        check_val("mrst_valid", out_valid, 0);
        check_val("mrst_addr", pbuf_rd_addr, 0);
        check_val("mrst_data", out_data, 0);
        repeat (10) @(negedge clk_l);
        check_val("mrst_quiet", {busy, out_valid}, 0);
        rand_drain();

        for (int n = 0; n < 25; n++) rand_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
